// File: rtl/alu_cmd_sequencer_if.sv
// Handshake and ALU-side bundle for the ALU command sequencer.
// slave = the sequencer's view, master = the command source / ALU / response sink.
interface alu_cmd_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic [3:0]       alu_op;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [7:0]       alu_res;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_res;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, alu_res, rsp_ready,
    output cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_res, rsp_tag, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, alu_res, rsp_ready,
    input  cmd_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_res, rsp_tag, rsp_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit combinational ALU: tagged command FIFO, registered
// operands, one-cycle execute, held response with divide/modulo-by-zero trap.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  alu_cmd_sequencer_if.slave       io,
  output logic [$clog2(DEPTH):0]   o_fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0]       op;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  cmd_t             r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [3:0]       r_alu_op;
  logic [7:0]       r_alu_a;
  logic [7:0]       r_alu_b;
  logic [TAG_W-1:0] r_tag;

  logic             r_rsp_valid;
  logic [7:0]       r_rsp_res;
  logic [TAG_W-1:0] r_rsp_tag;
  logic             r_rsp_err;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_div0;
  cmd_t             w_cmd_in;
  cmd_t             w_head;

  // Ready comes only from the registered count; a same-cycle pop never frees a slot.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = io.cmd_valid && !w_full;
  assign w_cmd_in = '{op: io.cmd_op, a: io.cmd_a, b: io.cmd_b, tag: io.cmd_tag};
  assign w_head   = r_mem[r_rd_ptr];
  assign w_div0   = ((r_alu_op == 4'b0011) || (r_alu_op == 4'b0100)) && (r_alu_b == 8'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: begin
        if (io.rsp_ready) begin
          w_pop       = !w_empty;
          w_state_nxt = w_empty ? S_IDLE : S_EXEC;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_cmd_in;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_tag       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_res   <= '0;
      r_rsp_tag   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_alu_op <= w_head.op;
        r_alu_a  <= w_head.a;
        r_alu_b  <= w_head.b;
        r_tag    <= w_head.tag;
      end
      if (r_state == S_EXEC) begin
        r_rsp_valid <= 1'b1;
        r_rsp_tag   <= r_tag;
        // The ALU result is undefined for a zero divisor, so substitute a fixed marker.
        if (w_div0) begin
          r_rsp_res <= 8'hFF;
          r_rsp_err <= 1'b1;
        end else begin
          r_rsp_res <= io.alu_res;
          r_rsp_err <= 1'b0;
        end
      end else if ((r_state == S_RESP) && io.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign io.cmd_ready  = !w_full;
  assign io.alu_op     = r_alu_op;
  assign io.alu_a      = r_alu_a;
  assign io.alu_b      = r_alu_b;
  assign io.rsp_valid  = r_rsp_valid;
  assign io.rsp_res    = r_rsp_res;
  assign io.rsp_tag    = r_rsp_tag;
  assign io.rsp_err    = r_rsp_err;
  assign o_fifo_count  = r_count;
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream issue stage for the 8-bit combinational ALU (op[3:0], A[7:0], B[7:0] -> res[7:0]).
- Buffers tagged ALU commands in a small FIFO and presents one command at a time on registered ALU operand/opcode outputs.
- Samples the ALU result and returns it with its tag on a valid/ready response port.
- Traps divide/modulo by zero so the ALU's undefined result never reaches the response port.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >= 2
TAG_W, 4, width of the command/response tag

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command offered
cmd_ready  output  1  command FIFO can accept; equals !full
cmd_op  input  4  ALU opcode (0000 add ... 1111 equal)
cmd_a  input  8  operand A
cmd_b  input  8  operand B
cmd_tag  input  TAG_W  command identifier, returned unchanged
alu_op  output  4  registered opcode to ALU op
alu_a  output  8  registered operand to ALU A
alu_b  output  8  registered operand to ALU B
alu_res  input  8  ALU res
rsp_valid  output  1  response held
rsp_ready  input  1  consumer accepts response
rsp_res  output  8  captured result
rsp_tag  output  TAG_W  tag of the completed command
rsp_err  output  1  1 = divide/modulo by zero trapped
fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=1 at a clk edge): FIFO empty, fifo_count=0, cmd_ready=1 on the following cycle, state IDLE; alu_op/alu_a/alu_b=0; rsp_valid=0, rsp_res=0, rsp_tag=0, rsp_err=0.
- Reset mid-operation discards all queued commands, the in-flight command and any held response. No response is produced for any of them.
- Push: occurs on cmd_valid && cmd_ready.
- cmd_ready depends only on the registered count. When full, a push is refused even if a pop happens in the same cycle.
- Push and pop in the same cycle when not full: count unchanged, both take effect.
- FIFO pointers wrap modulo DEPTH. Order is strictly FIFO.
- State machine, IDLE / EXEC / RESP:
  - IDLE: if FIFO non-empty, pop head into alu_op/alu_a/alu_b/tag register and go to EXEC. Otherwise stay.
  - EXEC (exactly 1 cycle; ALU inputs are stable): at the clock edge capture the result, set rsp_valid=1, and go to RESP.
    - Normal case: rsp_res <= alu_res, rsp_err <= 0.
    - If alu_op is 0011 or 0100 and alu_b == 0: rsp_res <= 8'hFF, rsp_err <= 1, and alu_res is ignored.
  - RESP: hold rsp_res/rsp_tag/rsp_err stable while rsp_valid && !rsp_ready.
    - On handshake: if FIFO non-empty, pop the next command into the ALU registers, clear rsp_valid and go to EXEC.
    - On handshake with FIFO empty: clear rsp_valid and go to IDLE.
- alu_op/alu_a/alu_b change only on a pop and otherwise hold their last value.
- Latency: a command accepted in cycle N into an empty, idle block gives rsp_valid=1 in cycle N+3.
- Throughput with rsp_ready held high: one response every 2 cycles.
- A command pushed in the same cycle the FIFO is seen empty is not popped until the next cycle. There is no bypass path.
- Results are 8 bits, truncated exactly as the ALU produces them. The sequencer does no arithmetic of its own.
- rsp_err is only ever set by the zero-divisor trap.

Test Plan:
- Reset then single command add (op 0000, A=8'd200, B=8'd100, tag 3), rsp_ready=1 -> rsp_valid exactly 3 cycles after accept, rsp_res=8'd44, rsp_tag=3, rsp_err=0.
- Four commands back-to-back (sub 9-4, mul 16*17, gt 5>3, eq 7==7), tags 0-3 -> cmd_ready stays high until count=4. Responses arrive in order: 5, 8'h10, 1, 1, with tags 0-3.
- Divide 8'd50/8'd0 then modulo 8'd50%8'd7 -> first response rsp_res=8'hFF, rsp_err=1. Second response rsp_res=1, rsp_err=0.
- Fill FIFO (count=4) with rsp_ready=0 and the FIFO head held in RESP, then offer a 5th command -> cmd_ready=0 and the command is not accepted. Hold rsp_ready low 10 cycles -> rsp_* stable throughout. Release rsp_ready -> all queued commands drain in order, and fifo_count decrements by 1 per pop.
- Random valid/ready toggling, 200 commands through a reference-model scoreboard -> no loss, no duplication, in-order tags, correct results, and no pointer glitch across FIFO wrap-around.
- Assert rst while in EXEC with 3 queued commands -> next cycle rsp_valid=0, fifo_count=0, alu_op/alu_a/alu_b=0. No stale response appears afterwards.
